// File: rtl/csa_acc_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator controller.
package csa_acc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } csa_state_e;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MAX_OPS = 8;

  // Width that holds max_ops worth of all-ones operands without overflow.
  function automatic int acc_w(input int width, input int max_ops);
    return width + $clog2(max_ops);
  endfunction

endpackage

// File: rtl/csa_row.sv
// Generic-width 3:2 carry-save row; carry output is unshifted.
module csa_row #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_accumulator_ctrl.sv
// Sequencer folding N operands into sum/carry vectors, then one carry-propagate add.
// Optional abort input enabled by defining CSA_ACC_ABORT_EN.
module csa_accumulator_ctrl
  import csa_acc_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_OPS = DEF_MAX_OPS,
  parameter int CNT_W   = $clog2(MAX_OPS + 1),
  parameter int ACC_W   = acc_w(WIDTH, MAX_OPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
`ifdef CSA_ACC_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy
);

  csa_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] s_vec_q, s_vec_d;
  logic [ACC_W-1:0] c_vec_q, c_vec_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;

  logic [ACC_W-1:0] row_s, row_c;
  logic [CNT_W-1:0] num_ops_clamped;

  assign num_ops_clamped = (num_ops > CNT_W'(MAX_OPS)) ? CNT_W'(MAX_OPS) : num_ops;

  csa_row #(.W(ACC_W)) u_row (
    .x (s_vec_q),
    .y (c_vec_q),
    .z (ACC_W'(in_data)),
    .s (row_s),
    .c (row_c)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_vec_d   = s_vec_q;
    c_vec_d   = c_vec_q;
    out_sum_d = out_sum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = num_ops_clamped;
          s_vec_d = '0;
          c_vec_d = '0;
          state_d = (num_ops_clamped == '0) ? RESOLVE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          s_vec_d = row_s;
          c_vec_d = row_c << 1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        out_sum_d = s_vec_q + c_vec_q;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef CSA_ACC_ABORT_EN
    // Abort never touches DONE, so a result once presented is always delivered.
    if (abort && (state_q == ACCUM || state_q == RESOLVE)) begin
      state_d   = IDLE;
      cnt_d     = '0;
      s_vec_d   = '0;
      c_vec_d   = '0;
      out_sum_d = out_sum_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s_vec_q   <= '0;
      c_vec_q   <= '0;
      out_sum_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_vec_q   <= s_vec_d;
      c_vec_q   <= c_vec_d;
      out_sum_q <= out_sum_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_csa_accumulator_ctrl.sv
// Randomized self-checking bench for csa_accumulator_ctrl against a plain-sum model.
module tb_csa_accumulator_ctrl;

  localparam int WIDTH   = 4;
  localparam int MAX_OPS = 8;
  localparam int CNT_W   = 4;
  localparam int ACC_W   = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_ops = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic             busy;
  logic             abort = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [WIDTH-1:0] ops_a [0:15];

  always #5 clk = ~clk;

  csa_accumulator_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_ops   (num_ops),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
`ifdef CSA_ACC_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy)
  );

  // Reference: the result is the plain sum of the accepted operands, modulo 2^ACC_W.
  function automatic int model_sum(input int n);
    int acc = 0;
    for (int i = 0; i < n; i++) acc += int'(ops_a[i]);
    return acc % (1 << ACC_W);
  endfunction

  // Starts a job, feeds n_send operands, waits for out_valid (bounded); lat counts
  // negedges after the one following the last accept edge until out_valid is seen.
  task automatic drive_job(input int n_prog, input int n_send, input bit bub,
                           output int lat, output bit rdy_ok);
    @(negedge clk);
    start = 1'b1;
    num_ops = CNT_W'(n_prog);
    @(negedge clk);
    start = 1'b0;
    rdy_ok = 1'b1;
    for (int i = 0; i < n_send; i++) begin
      if (bub && i > 0) begin
        in_valid = 1'b0;
        in_data = 4'(($urandom));
        @(negedge clk);
        if (!in_ready) rdy_ok = 1'b0;
      end
      in_valid = 1'b1;
      in_data = ops_a[i];
      if (!in_ready) rdy_ok = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++;
    if ({busy, in_ready, out_valid, out_sum} !== '0)
      $display("FAIL reset_held: got busy=%b rdy=%b vld=%b sum=%0d, want all 0",
               busy, in_ready, out_valid, out_sum);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({busy, in_ready, out_valid, out_sum} !== '0)
      $display("FAIL reset_released: got busy=%b rdy=%b vld=%b sum=%0d, want all 0",
               busy, in_ready, out_valid, out_sum);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat; bit rdy;
    for (int i = 0; i < 3; i++) ops_a[i] = 4'd1;
    drive_job(3, 3, 1'b0, lat, rdy);
    total_cnt++;
    if (lat !== 1 || out_sum !== 7'd3)
      $display("FAIL basic_3x1: got lat=%0d sum=%0d, want lat=1 sum=3", lat, out_sum);
    else pass_cnt++;
    total_cnt++;
    if (!rdy) $display("FAIL basic_ready: got in_ready dropped, want 1 throughout");
    else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 7'd3)
      $display("FAIL basic_handshake: got vld=%b busy=%b sum=%0d, want 0 0 3",
               out_valid, busy, out_sum);
    else pass_cnt++;
  endtask

  task automatic test_full();
    int lat; bit rdy;
    for (int i = 0; i < 8; i++) ops_a[i] = 4'd15;
    drive_job(8, 8, 1'b0, lat, rdy);
    total_cnt++;
    if (lat !== 1 || out_sum !== 7'd120)
      $display("FAIL full_8x15: got lat=%0d sum=%0d, want lat=1 sum=120", lat, out_sum);
    else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_bubbles();
    int lat; bit rdy;
    ops_a[0] = 4'd5; ops_a[1] = 4'd9; ops_a[2] = 4'd0; ops_a[3] = 4'd14;
    drive_job(4, 4, 1'b1, lat, rdy);
    total_cnt++;
    if (lat !== 1 || out_sum !== 7'd28 || !rdy)
      $display("FAIL bubbles: got lat=%0d sum=%0d rdy_ok=%b, want 1 28 1", lat, out_sum, rdy);
    else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_hold_done();
    int lat; bit rdy;
    logic [ACC_W-1:0] want;
    for (int i = 0; i < 5; i++) ops_a[i] = 4'($urandom);
    want = ACC_W'(model_sum(5));
    drive_job(5, 5, 1'b0, lat, rdy);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      num_ops = 4'd2;
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || out_sum !== want)
        $display("FAIL hold_done_%0d: got vld=%b sum=%0d, want 1 %0d", c, out_valid, out_sum, want);
      else pass_cnt++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== want)
      $display("FAIL hold_release: got vld=%b busy=%b sum=%0d, want 0 0 %0d",
               out_valid, busy, out_sum, want);
    else pass_cnt++;
  endtask

  task automatic test_zero_and_rst();
    int lat; bit rdy; bit seen;
    drive_job(0, 0, 1'b0, lat, rdy);
    total_cnt++;
    if (lat !== 1 || out_sum !== 7'd0)
      $display("FAIL zero_ops: got lat=%0d sum=%0d, want lat=1 sum=0", lat, out_sum);
    else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    // Give out_sum a nonzero value first so the async clear is visible.
    ops_a[0] = 4'd7;
    drive_job(1, 1, 1'b0, lat, rdy);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; num_ops = 4'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 4'd3;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, in_ready, out_valid, out_sum} !== '0)
      $display("FAIL async_reset: got busy=%b rdy=%b vld=%b sum=%0d, want all 0",
               busy, in_ready, out_valid, out_sum);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    total_cnt++;
    if (seen) $display("FAIL post_reset_quiet: got activity after reset, want none");
    else pass_cnt++;
  endtask

  task automatic test_random();
    int lat; bit rdy; int n_prog; int n_eff; bit bub;
    logic [ACC_W-1:0] want;
    for (int j = 0; j < 20; j++) begin
      n_prog = int'($urandom_range(0, 15));
      n_eff = (n_prog > MAX_OPS) ? MAX_OPS : n_prog;
      bub = 1'($urandom);
      for (int i = 0; i < 16; i++) ops_a[i] = 4'($urandom);
      want = ACC_W'(model_sum(n_eff));
      drive_job(n_prog, n_eff, bub, lat, rdy);
      total_cnt++;
      if (lat !== 1 || out_sum !== want || !rdy)
        $display("FAIL random_job_%0d: got n=%0d lat=%0d sum=%0d rdy_ok=%b, want lat=1 sum=%0d rdy_ok=1",
                 j, n_prog, lat, out_sum, rdy, want);
      else pass_cnt++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

`ifdef CSA_ACC_ABORT_EN
  task automatic test_abort();
    int lat; bit rdy; bit seen;
    @(negedge clk);
    start = 1'b1; num_ops = 4'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 4'd9;
      @(negedge clk);
    end
    in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL abort_idle: got busy=%b vld=%b, want 0 0", busy, out_valid);
    else pass_cnt++;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total_cnt++;
    if (seen) $display("FAIL abort_no_valid: got out_valid after abort, want none");
    else pass_cnt++;
    ops_a[0] = 4'd2; ops_a[1] = 4'd3;
    drive_job(2, 2, 1'b0, lat, rdy);
    total_cnt++;
    if (lat !== 1 || out_sum !== 7'd5)
      $display("FAIL abort_followup: got lat=%0d sum=%0d, want lat=1 sum=5", lat, out_sum);
    else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_bubbles();
    test_hold_done();
    test_zero_and_rst();
    test_random();
`ifdef CSA_ACC_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
